// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl
//   Load/store unit between the core datapath and a word-wide, single-port
//   data RAM with one write enable. Adds byte/halfword/word loads and stores:
//   sub-word loads are lane-extracted and extended, sub-word stores are done
//   as a read-modify-write. Misaligned, out-of-range and illegal-funct3
//   requests complete with rsp_err_o and never touch the RAM.
//
// Ports
//   clk_i, reset_i          clock, asynchronous active-high reset
//   req_valid_i/ready_o     request handshake; ready only in IDLE
//   req_we_i                1 = store, 0 = load
//   req_funct3_i            RISC-V funct3 (size / sign)
//   req_addr_i              byte address
//   req_wdata_i             store data (rs2)
//   rsp_valid_o             one-cycle completion pulse
//   rsp_err_o               error qualifier for rsp_valid_o
//   rsp_rdata_o             extended load data (0 for stores / errors)
//   mem_en_o, mem_we_o      RAM enable / write enable
//   mem_addr_o              RAM word address
//   mem_wdata_o             RAM write data
//   mem_rdata_i             RAM read data, MEM_LAT cycles after the read cycle
module lsu_mem_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int MEM_LAT = 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [31:0]       req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              rsp_valid_o,
  output logic              rsp_err_o,
  output logic [31:0]       rsp_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WAIT,
    S_WR,
    S_RESP
  } state_t;

  state_t              state_q;
  logic                we_q;
  logic [2:0]          f3_q;
  logic [1:0]          off_q;     // byte offset within the word
  logic [15:0]         wdata_q;   // only the sub-word store lanes are needed later
  logic [CW-1:0]       cnt_q;

  logic                req_ready_q;
  logic                rsp_valid_q;
  logic                rsp_err_q;
  logic [31:0]         rsp_rdata_q;
  logic                mem_en_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [31:0]         mem_wdata_q;

  // Request classification (only consumed on the accept edge).
  logic                f3_legal;
  logic                misalign;
  logic                out_of_range;
  logic                req_err_d;

  always_comb begin
    f3_legal = 1'b0;
    if (req_we_i)
      f3_legal = req_funct3_i inside {3'b000, 3'b001, 3'b010};
    else
      f3_legal = req_funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    misalign     = ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0]) ||
                   ((req_funct3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00));
    out_of_range = (req_addr_i >> (ADDR_W + 2)) != 32'd0;
    req_err_d    = !f3_legal || misalign || out_of_range;
  end

  // Load extension and store lane merge, both working on the raw RAM word
  // that is present on the last WAIT edge.
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext_d;
  logic [31:0] st_word_d;

  always_comb begin
    ld_byte  = mem_rdata_i[{off_q, 3'b000} +: 8];
    ld_half  = mem_rdata_i[{off_q[1], 4'b0000} +: 16];
    ld_ext_d = mem_rdata_i;
    case (f3_q)
      3'b000:  ld_ext_d = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext_d = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext_d = {24'd0, ld_byte};
      3'b101:  ld_ext_d = {16'd0, ld_half};
      default: ld_ext_d = mem_rdata_i;
    endcase

    st_word_d = mem_rdata_i;
    case (f3_q[1:0])
      2'b00:   st_word_d[{off_q, 3'b000} +: 8]     = wdata_q[7:0];
      2'b01:   st_word_d[{off_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: st_word_d = mem_rdata_i;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      f3_q        <= 3'd0;
      off_q       <= 2'd0;
      wdata_q     <= 16'd0;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'd0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            we_q        <= req_we_i;
            f3_q        <= req_funct3_i;
            off_q       <= req_addr_i[1:0];
            wdata_q     <= req_wdata_i[15:0];
            req_ready_q <= 1'b0;
            if (req_err_d) begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= 32'd0;
            end else if (req_we_i && (req_funct3_i == 3'b010)) begin
              // Full-word store needs no read.
              state_q     <= S_WR;
              mem_en_q    <= 1'b1;
              mem_we_q    <= 1'b1;
              mem_addr_q  <= req_addr_i[ADDR_W+1:2];
              mem_wdata_q <= req_wdata_i;
            end else begin
              state_q    <= S_RD;
              mem_en_q   <= 1'b1;
              mem_we_q   <= 1'b0;
              mem_addr_q <= req_addr_i[ADDR_W+1:2];
            end
          end
        end
        S_RD: begin
          state_q  <= S_WAIT;
          mem_en_q <= 1'b0;
          mem_we_q <= 1'b0;
          cnt_q    <= '0;
        end
        S_WAIT: begin
          if (cnt_q == CW'(MEM_LAT - 1)) begin
            if (we_q) begin
              state_q     <= S_WR;
              mem_en_q    <= 1'b1;
              mem_we_q    <= 1'b1;
              mem_wdata_q <= st_word_d;
            end else begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b0;
              rsp_rdata_q <= ld_ext_d;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_WR: begin
          state_q     <= S_RESP;
          mem_en_q    <= 1'b0;
          mem_we_q    <= 1'b0;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= 32'd0;
        end
        S_RESP: begin
          // rsp_err/rsp_rdata deliberately hold until the next response.
          state_q     <= S_IDLE;
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
          mem_en_q    <= 1'b0;
          mem_we_q    <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: two instances (MEM_LAT=1 and MEM_LAT=3), each with
// its own behavioural RAM. A directed vector table runs on both, followed by
// reset-abort and back-to-back sequences.
module tb_lsu_mem_ctrl;

  logic        clk;
  logic        rst       [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [2:0]  req_f3    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        rsp_valid [2];
  logic        rsp_err   [2];
  logic [31:0] rsp_rdata [2];
  logic        mem_en    [2];
  logic        mem_we    [2];
  logic [7:0]  mem_addr  [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];

  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  lsu_mem_ctrl #(.ADDR_W(8), .MEM_LAT(LAT0)) u_dut0 (
    .clk_i(clk), .reset_i(rst[0]),
    .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
    .req_we_i(req_we[0]), .req_funct3_i(req_f3[0]),
    .req_addr_i(req_addr[0]), .req_wdata_i(req_wdata[0]),
    .rsp_valid_o(rsp_valid[0]), .rsp_err_o(rsp_err[0]), .rsp_rdata_o(rsp_rdata[0]),
    .mem_en_o(mem_en[0]), .mem_we_o(mem_we[0]), .mem_addr_o(mem_addr[0]),
    .mem_wdata_o(mem_wdata[0]), .mem_rdata_i(mem_rdata[0])
  );

  lsu_mem_ctrl #(.ADDR_W(8), .MEM_LAT(LAT1)) u_dut1 (
    .clk_i(clk), .reset_i(rst[1]),
    .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
    .req_we_i(req_we[1]), .req_funct3_i(req_f3[1]),
    .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]),
    .rsp_valid_o(rsp_valid[1]), .rsp_err_o(rsp_err[1]), .rsp_rdata_o(rsp_rdata[1]),
    .mem_en_o(mem_en[1]), .mem_we_o(mem_we[1]), .mem_addr_o(mem_addr[1]),
    .mem_wdata_o(mem_wdata[1]), .mem_rdata_i(mem_rdata[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAMs. Preload goes through pre_* so only this block writes ram.
  logic [31:0] ram  [2][256];
  logic [31:0] pipe [2][3];
  int          rd_cnt [2];
  int          wr_cnt [2];
  logic        pre_en  [2];
  logic        pre_clr [2];
  logic [7:0]  pre_idx [2];
  logic [31:0] pre_val [2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      rd_cnt[i] = 0;
      wr_cnt[i] = 0;
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (mem_en[i] && !mem_we[i]) pipe[i][0] <= ram[i][mem_addr[i]];
      else                         pipe[i][0] <= 32'h0BAD0BAD;
      pipe[i][1] <= pipe[i][0];
      pipe[i][2] <= pipe[i][1];
      if (mem_en[i]) begin
        if (mem_we[i]) begin
          ram[i][mem_addr[i]] = mem_wdata[i];
          wr_cnt[i] = wr_cnt[i] + 1;
        end else begin
          rd_cnt[i] = rd_cnt[i] + 1;
        end
      end
      if (pre_clr[i])
        for (int k = 0; k < 256; k++) ram[i][k] = 32'd0;
      if (pre_en[i]) ram[i][pre_idx[i]] = pre_val[i];
    end
  end

  assign mem_rdata[0] = pipe[0][LAT0-1];
  assign mem_rdata[1] = pipe[1][LAT1-1];

  int n_vec;
  int n_chk;
  int n_err;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endfunction

  task automatic preload(input int i, input logic [7:0] idx, input logic [31:0] val);
    @(negedge clk);
    pre_en[i]  = 1'b1;
    pre_idx[i] = idx;
    pre_val[i] = val;
    @(negedge clk);
    pre_en[i]  = 1'b0;
  endtask

  task automatic clear_ram(input int i);
    @(negedge clk);
    pre_clr[i] = 1'b1;
    @(negedge clk);
    pre_clr[i] = 1'b0;
  endtask

  // Waits (bounded) at a negedge for req_ready.
  task automatic wait_ready(input int i);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready[i] && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[i]) chk($sformatf("inst%0d ready timeout", i), 32'(req_ready[i]), 32'd1);
  endtask

  // Issues one request; lat = index of the negedge (1 = first after accept)
  // where rsp_valid is seen, 0 on timeout.
  task automatic run_req(input int i, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic err, output logic [31:0] rd, output int lat,
                         output int nrd, output int nwr);
    int r0, w0;
    wait_ready(i);
    r0 = rd_cnt[i];
    w0 = wr_cnt[i];
    req_valid[i] = 1'b1;
    req_we[i]    = we;
    req_f3[i]    = f3;
    req_addr[i]  = a;
    req_wdata[i] = wd;
    lat = 0;
    err = 1'bx;
    rd  = 32'hx;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 1) req_valid[i] = 1'b0;
      if (rsp_valid[i]) begin
        lat = n;
        err = rsp_err[i];
        rd  = rsp_rdata[i];
        break;
      end
    end
    nrd = rd_cnt[i] - r0;
    nwr = wr_cnt[i] - w0;
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    int          lat_base;  // latency excluding MEM_LAT
    bit          add_lat;   // add MEM_LAT to latency
    int          nrd;
    int          nwr;
    logic [7:0]  widx;      // RAM word checked afterwards
    logic [31:0] wexp;
  } vec_t;

  localparam int NV = 23;
  vec_t tv [NV];

  initial begin
    tv[0]  = '{1'b0, 3'b010, 32'h0000000C, 32'h0,        1'b0, 32'hDEADBEEF, 2, 1'b1, 1, 0, 8'd3,   32'hDEADBEEF};
    tv[1]  = '{1'b0, 3'b000, 32'h0000000E, 32'h0,        1'b0, 32'hFFFFFFAD, 2, 1'b1, 1, 0, 8'd3,   32'hDEADBEEF};
    tv[2]  = '{1'b0, 3'b100, 32'h0000000E, 32'h0,        1'b0, 32'h000000AD, 2, 1'b1, 1, 0, 8'd3,   32'hDEADBEEF};
    tv[3]  = '{1'b0, 3'b001, 32'h0000000C, 32'h0,        1'b0, 32'hFFFFBEEF, 2, 1'b1, 1, 0, 8'd3,   32'hDEADBEEF};
    tv[4]  = '{1'b0, 3'b101, 32'h0000000E, 32'h0,        1'b0, 32'h0000DEAD, 2, 1'b1, 1, 0, 8'd3,   32'hDEADBEEF};
    tv[5]  = '{1'b0, 3'b000, 32'h0000000D, 32'h0,        1'b0, 32'hFFFFFFBE, 2, 1'b1, 1, 0, 8'd3,   32'hDEADBEEF};
    tv[6]  = '{1'b0, 3'b100, 32'h0000000F, 32'h0,        1'b0, 32'h000000DE, 2, 1'b1, 1, 0, 8'd3,   32'hDEADBEEF};
    tv[7]  = '{1'b1, 3'b000, 32'h00000015, 32'hFFFFFFAA, 1'b0, 32'h0,        3, 1'b1, 1, 1, 8'd5,   32'h1122AA44};
    tv[8]  = '{1'b1, 3'b001, 32'h00000016, 32'h12345678, 1'b0, 32'h0,        3, 1'b1, 1, 1, 8'd5,   32'h5678AA44};
    tv[9]  = '{1'b1, 3'b000, 32'h00000017, 32'h00000080, 1'b0, 32'h0,        3, 1'b1, 1, 1, 8'd5,   32'h8078AA44};
    tv[10] = '{1'b0, 3'b001, 32'h00000016, 32'h0,        1'b0, 32'hFFFF8078, 2, 1'b1, 1, 0, 8'd5,   32'h8078AA44};
    tv[11] = '{1'b1, 3'b010, 32'h00000014, 32'hCAFEF00D, 1'b0, 32'h0,        2, 1'b0, 0, 1, 8'd5,   32'hCAFEF00D};
    tv[12] = '{1'b0, 3'b010, 32'h00000014, 32'h0,        1'b0, 32'hCAFEF00D, 2, 1'b1, 1, 0, 8'd5,   32'hCAFEF00D};
    tv[13] = '{1'b0, 3'b010, 32'h000003FC, 32'h0,        1'b0, 32'hA5A55A5A, 2, 1'b1, 1, 0, 8'd255, 32'hA5A55A5A};
    tv[14] = '{1'b0, 3'b010, 32'h0000000D, 32'h0,        1'b1, 32'h0,        1, 1'b0, 0, 0, 8'd3,   32'hDEADBEEF};
    tv[15] = '{1'b1, 3'b001, 32'h00000003, 32'h0000FFFF, 1'b1, 32'h0,        1, 1'b0, 0, 0, 8'd0,   32'h00000000};
    tv[16] = '{1'b1, 3'b010, 32'h00000400, 32'h12345678, 1'b1, 32'h0,        1, 1'b0, 0, 0, 8'd0,   32'h00000000};
    tv[17] = '{1'b0, 3'b011, 32'h0000000C, 32'h0,        1'b1, 32'h0,        1, 1'b0, 0, 0, 8'd3,   32'hDEADBEEF};
    tv[18] = '{1'b1, 3'b100, 32'h00000014, 32'h11111111, 1'b1, 32'h0,        1, 1'b0, 0, 0, 8'd5,   32'hCAFEF00D};
    tv[19] = '{1'b0, 3'b101, 32'h0000000F, 32'h0,        1'b1, 32'h0,        1, 1'b0, 0, 0, 8'd3,   32'hDEADBEEF};
    tv[20] = '{1'b0, 3'b010, 32'hFFFFFFFC, 32'h0,        1'b1, 32'h0,        1, 1'b0, 0, 0, 8'd255, 32'hA5A55A5A};
    tv[21] = '{1'b1, 3'b001, 32'h00000002, 32'h0000BEEF, 1'b0, 32'h0,        3, 1'b1, 1, 1, 8'd0,   32'hBEEF0000};
    tv[22] = '{1'b0, 3'b000, 32'h00000003, 32'h0,        1'b0, 32'hFFFFFFBE, 2, 1'b1, 1, 0, 8'd0,   32'hBEEF0000};
  end

  task automatic chk_idle(input int i, input string tag);
    chk($sformatf("%s inst%0d req_ready", tag, i), 32'(req_ready[i]), 32'd1);
    chk($sformatf("%s inst%0d rsp_valid", tag, i), 32'(rsp_valid[i]), 32'd0);
    chk($sformatf("%s inst%0d rsp_err", tag, i),   32'(rsp_err[i]),   32'd0);
    chk($sformatf("%s inst%0d rsp_rdata", tag, i), rsp_rdata[i],      32'd0);
    chk($sformatf("%s inst%0d mem_en", tag, i),    32'(mem_en[i]),    32'd0);
    chk($sformatf("%s inst%0d mem_we", tag, i),    32'(mem_we[i]),    32'd0);
    chk($sformatf("%s inst%0d mem_addr", tag, i),  32'(mem_addr[i]),  32'd0);
    chk($sformatf("%s inst%0d mem_wdata", tag, i), mem_wdata[i],      32'd0);
  endtask

  task automatic run_table(input int i, input int lat_mem);
    logic        err;
    logic [31:0] rd;
    int          lat, nrd, nwr, exp_lat;
    clear_ram(i);
    preload(i, 8'd3,   32'hDEADBEEF);
    preload(i, 8'd5,   32'h11223344);
    preload(i, 8'd255, 32'hA5A55A5A);
    for (int v = 0; v < NV; v++) begin
      run_req(i, tv[v].we, tv[v].f3, tv[v].addr, tv[v].wdata, err, rd, lat, nrd, nwr);
      n_vec++;
      exp_lat = tv[v].lat_base + (tv[v].add_lat ? lat_mem : 0);
      chk($sformatf("i%0d v%0d latency", i, v), 32'(lat),  32'(exp_lat));
      chk($sformatf("i%0d v%0d rsp_err", i, v), 32'(err),  32'(tv[v].err));
      chk($sformatf("i%0d v%0d rsp_rdata", i, v), rd,     tv[v].rdata);
      chk($sformatf("i%0d v%0d ram reads", i, v), 32'(nrd), 32'(tv[v].nrd));
      chk($sformatf("i%0d v%0d ram writes", i, v), 32'(nwr), 32'(tv[v].nwr));
      chk($sformatf("i%0d v%0d ram word", i, v), ram[i][tv[v].widx], tv[v].wexp);
      // Next cycle: pulse over, response fields held.
      @(negedge clk);
      chk($sformatf("i%0d v%0d pulse width", i, v), 32'(rsp_valid[i]), 32'd0);
      chk($sformatf("i%0d v%0d rdata hold", i, v), rsp_rdata[i], tv[v].rdata);
      chk($sformatf("i%0d v%0d err hold", i, v), 32'(rsp_err[i]), 32'(tv[v].err));
    end
  endtask

  // Sub-word store aborted by reset in WAIT (at_n=2) or WR (at_n=3).
  task automatic reset_abort(input int at_n);
    int w0, pulses;
    preload(0, 8'd7, 32'h55667788);
    wait_ready(0);
    w0 = wr_cnt[0];
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b1;
    req_f3[0]    = 3'b000;
    req_addr[0]  = 32'h0000001C;
    req_wdata[0] = 32'h00000099;
    for (int n = 1; n <= at_n; n++) begin
      @(negedge clk);
      req_valid[0] = 1'b0;
      if (n == 1) chk($sformatf("rst@%0d RD mem_en", at_n), 32'(mem_en[0]), 32'd1);
    end
    if (at_n == 3) chk("rst@3 WR mem_we", 32'(mem_we[0]), 32'd1);
    rst[0] = 1'b1;
    #1;
    chk($sformatf("rst@%0d async ready", at_n),  32'(req_ready[0]), 32'd1);
    chk($sformatf("rst@%0d async mem_en", at_n), 32'(mem_en[0]),    32'd0);
    chk($sformatf("rst@%0d async mem_we", at_n), 32'(mem_we[0]),    32'd0);
    pulses = 0;
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      if (rsp_valid[0]) pulses++;
    end
    rst[0] = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (rsp_valid[0]) pulses++;
    end
    n_vec++;
    chk($sformatf("rst@%0d rsp pulses", at_n), 32'(pulses), 32'd0);
    chk($sformatf("rst@%0d ram writes", at_n), 32'(wr_cnt[0] - w0), 32'd0);
    chk($sformatf("rst@%0d ram word", at_n), ram[0][7], 32'h55667788);
    chk_idle(0, $sformatf("rst@%0d after", at_n));
  endtask

  // SW then LW with req_valid held high throughout.
  task automatic back_to_back(input int i, input int lat_mem);
    int          first_n, second_n;
    logic [31:0] d, got;
    d = 32'h600DF00D ^ 32'(i);
    wait_ready(i);
    req_valid[i] = 1'b1;
    req_we[i]    = 1'b1;
    req_f3[i]    = 3'b010;
    req_addr[i]  = 32'h0;
    req_wdata[i] = d;
    first_n  = 0;
    second_n = 0;
    got      = 32'h0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (n == 1) begin
        req_we[i]    = 1'b0;
        req_wdata[i] = 32'h0;
        chk($sformatf("b2b i%0d ready busy", i), 32'(req_ready[i]), 32'd0);
      end
      if (n == 2) chk($sformatf("b2b i%0d ready in RESP", i), 32'(req_ready[i]), 32'd0);
      if (n == 3) chk($sformatf("b2b i%0d ready in IDLE", i), 32'(req_ready[i]), 32'd1);
      if (n == 4) req_valid[i] = 1'b0;
      if (rsp_valid[i]) begin
        if (first_n == 0) first_n = n;
        else if (second_n == 0) begin
          second_n = n;
          got      = rsp_rdata[i];
        end
      end
    end
    n_vec++;
    chk($sformatf("b2b i%0d SW rsp cycle", i), 32'(first_n),  32'd2);
    chk($sformatf("b2b i%0d LW rsp cycle", i), 32'(second_n), 32'(5 + lat_mem));
    chk($sformatf("b2b i%0d LW data", i), got, d);
    chk($sformatf("b2b i%0d ram word", i), ram[i][0], d);
  endtask

  initial begin
    n_vec = 0;
    n_chk = 0;
    n_err = 0;
    for (int i = 0; i < 2; i++) begin
      rst[i]       = 1'b1;
      req_valid[i] = 1'b0;
      req_we[i]    = 1'b0;
      req_f3[i]    = 3'd0;
      req_addr[i]  = 32'd0;
      req_wdata[i] = 32'd0;
      pre_en[i]    = 1'b0;
      pre_clr[i]   = 1'b0;
      pre_idx[i]   = 8'd0;
      pre_val[i]   = 32'd0;
    end
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) chk_idle(i, "in reset");
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) chk_idle(i, "after reset");
    n_vec++;

    run_table(0, LAT0);
    run_table(1, LAT1);
    reset_abort(2);
    reset_abort(3);
    back_to_back(0, LAT0);
    back_to_back(1, LAT1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
